cache_mem_arbiter: RTL

Arbitrates the instruction cache and data cache onto the single-ported RAM. Dcache has priority, and a dcache access holds the RAM across both words of a block transfer (load, writeback, write-miss fill). An optional starvation guard forces an icache slot after repeated dcache block transfers. Sits between `icache`/`dcache` and the RAM model in the memory subsystem.

---
 rtl/cache_mem_arbiter_pkg.sv | 21 ++
 rtl/cache_mem_arbiter_if.sv | 31 +++
 rtl/cache_mem_arbiter_starve_ctr.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared CPU memory types plus the cache/RAM arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBUS = 2'd1,
    IBUS = 2'd2
  } arb_state_t;

  localparam int ARB_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache request/response and RAM port bundle seen by the arbiter.
interface cache_mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter_starve_ctr.sv
// Saturating count of dcache block completions seen while icache waits.
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // hit fires on the increment that would make the count reach LIMIT
  assign hit = inc && (cnt >= CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_next = cnt;
    if (clr || hit) begin
      cnt_next = '0;
    end else if (inc && (cnt < CNT_W'(LIMIT))) begin
      cnt_next = cnt + CNT_W'(1);
    end else begin
      cnt_next = cnt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Dcache-priority arbiter for icache/dcache onto one RAM port.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = 3
) (
  input logic               CLK,
  input logic               RST,
  cache_mem_arbiter_if.slave bus
);
  arb_state_t state;
  arb_state_t state_next;
  logic       dreq;
  logic       ram_done;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_hit;

  assign dreq     = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS);

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_starve (
    .CLK(CLK),
    .RST(RST),
    .inc(starve_inc),
    .clr(starve_clr),
    .hit(starve_hit)
  );
`else
  logic unused_cfg;
  assign starve_hit = 1'b0;
  assign unused_cfg = ^{starve_inc, starve_clr, CNT_W'(STARVE_LIMIT)};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0000_0000;
    bus.ramstore = 32'h0000_0000;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = 32'h0000_0000;
    bus.dload    = 32'h0000_0000;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (dreq) begin
          state_next = DBUS;
        end else if (bus.iREN) begin
          state_next = IBUS;
        end else begin
          state_next = IDLE;
        end
      end
      DBUS: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~ram_done;
        bus.dload    = bus.ramload;
        // second word of a block finishing while icache is still waiting
        starve_inc   = ram_done & bus.daddr[2] & bus.iREN;
        if (!dreq) begin
          state_next = bus.iREN ? IBUS : IDLE;
        end else if (starve_hit) begin
          state_next = IBUS;
        end else begin
          state_next = DBUS;
        end
      end
      IBUS: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        bus.iwait   = ~ram_done;
        bus.iload   = bus.ramload;
        if (ram_done) begin
          starve_clr = 1'b1;
          state_next = dreq ? DBUS : (bus.iREN ? IBUS : IDLE);
        end else if (!bus.iREN) begin
          state_next = dreq ? DBUS : IDLE;
        end else begin
          state_next = IBUS;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule
